// File: rtl/pmod_pkg.sv
// Shared types and defaults for the PMOD serial receiver.
package pmod_pkg;

  localparam int unsigned PMOD_FRAME_BITS = 16;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    CLOSE     = 2'd3
  } rx_state_t;

endpackage

// File: rtl/pmod_rx_fifo.sv
// First-word-fall-through word FIFO for the PMOD receiver (PMOD_RX_FIFO_EN builds only).
// DEPTH must be a power of two, at least 2.
module pmod_rx_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;

  // A write while full is only issued together with a pop; the overwritten
  // slot is the head that leaves in that same cycle.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign rd_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/pmod_receiver.sv
// Chip-select framed, LSB-first serial receiver with valid/ready output.
// Define PMOD_RX_FIFO_EN to replace the single holding register with a FIFO.
module pmod_receiver
  import pmod_pkg::*;
#(
  parameter int FRAME_BITS  = PMOD_FRAME_BITS,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CS_N,
  input  logic                  SDI,
  input  logic                  SCLK,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  overflow,
  output logic                  busy
);

  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam int SW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);
  localparam logic [SW-1:0] SETTLE   = SW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic [SYNC_STAGES-1:0] sdi_sync_reg;
  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic                   cs_d_reg;
  logic                   sclk_d_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cs_sync_reg   <= '1;
      sdi_sync_reg  <= '1;
      sclk_sync_reg <= '1;
      cs_d_reg      <= 1'b1;
      sclk_d_reg    <= 1'b1;
    end else begin
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], CS_N};
      sdi_sync_reg  <= {sdi_sync_reg[SYNC_STAGES-2:0], SDI};
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], SCLK};
      cs_d_reg      <= cs_sync_reg[SYNC_STAGES-1];
      sclk_d_reg    <= sclk_sync_reg[SYNC_STAGES-1];
    end
  end

  logic cs_s, sdi_s, sclk_s;
  logic cs_fall, cs_rise, sclk_fall;

  assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_reg[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign cs_fall   = cs_d_reg & ~cs_s;
  assign cs_rise   = ~cs_d_reg & cs_s;
  assign sclk_fall = sclk_d_reg & ~sclk_s;

  rx_state_t             state_reg;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [CW-1:0]         bit_cnt_reg;
  logic [SW-1:0]         settle_reg;
  logic                  frame_err_reg;

  // WAIT_IDLE first lets the synchronizers refill from the pins, since their
  // reset value of 1 would otherwise fake an idle bus mid-frame.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= WAIT_IDLE;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      settle_reg    <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      case (state_reg)
        WAIT_IDLE: begin
          if (settle_reg != SETTLE)
            settle_reg <= settle_reg + SW'(1);
          else if (cs_s && cs_d_reg)
            state_reg <= IDLE;
        end
        IDLE: begin
          if (cs_fall) begin
            state_reg   <= SHIFT;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
          end
        end
        SHIFT: begin
          if (sclk_fall) begin
            shift_reg <= {sdi_s, shift_reg[FRAME_BITS-1:1]};
            if (bit_cnt_reg != CNT_SAT) bit_cnt_reg <= bit_cnt_reg + CW'(1);
          end
          if (cs_rise) state_reg <= CLOSE;
        end
        CLOSE: begin
          frame_err_reg <= (bit_cnt_reg != CNT_FULL);
          state_reg     <= IDLE;
        end
        default: state_reg <= WAIT_IDLE;
      endcase
    end
  end

  logic push, pop, buf_full, overflow_reg;

  assign push      = (state_reg == CLOSE) && (bit_cnt_reg == CNT_FULL);
  assign pop       = rx_valid && rx_ready;
  assign busy      = (state_reg == SHIFT);
  assign frame_err = frame_err_reg;
  assign overflow  = overflow_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) overflow_reg <= 1'b0;
    else        overflow_reg <= push && buf_full && !pop;
  end

`ifdef PMOD_RX_FIFO_EN
  logic fifo_empty, fifo_full, fifo_wr;

  assign fifo_wr  = push && (!fifo_full || pop);
  assign buf_full = fifo_full;
  assign rx_valid = !fifo_empty;

  pmod_rx_fifo #(
    .W     (FRAME_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .wr_en   (fifo_wr),
    .wr_data (shift_reg),
    .rd_en   (pop),
    .rd_data (rx_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );
`else
  logic [FRAME_BITS-1:0] hold_data_reg;
  logic                  hold_valid_reg;
  logic                  unused_depth;

  assign unused_depth = (FIFO_DEPTH == 0);
  assign buf_full     = hold_valid_reg;
  assign rx_valid     = hold_valid_reg;
  assign rx_data      = hold_data_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_data_reg  <= '0;
      hold_valid_reg <= 1'b0;
    end else if (push && (!hold_valid_reg || pop)) begin
      hold_data_reg  <= shift_reg;
      hold_valid_reg <= 1'b1;
    end else if (pop) begin
      hold_valid_reg <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pmod_receiver.sv
// Scoreboard bench for pmod_receiver: frame-level reference model, queue of
// expected words, independent monitor. Honors PMOD_RX_FIFO_EN for buffer depth.
module tb_pmod_receiver;

  localparam int FB   = 16;
  localparam int SYNC = 2;
`ifdef PMOD_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          CS_N = 1'b1;
  logic          SDI = 1'b0;
  logic          SCLK = 1'b0;
  logic          rx_ready = 1'b0;
  logic [FB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overflow;
  logic          busy;

  pmod_receiver #(
    .FRAME_BITS  (FB),
    .SYNC_STAGES (SYNC),
    .FIFO_DEPTH  (4)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CS_N      (CS_N),
    .SDI       (SDI),
    .SCLK      (SCLK),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  logic [FB-1:0] exp_q[$];
  int exp_ferr = 0, exp_ovf = 0;
  int got_ferr = 0, got_ovf = 0;
  int n_xfer = 0, xfer_base = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Reference model: a closed frame is good only with exactly FB bits; a good
  // word is kept unless the buffer already holds CAP words and nothing leaves.
  task automatic model_close(input logic [FB-1:0] word, input int nbits, input bit pop_same);
    if (nbits != FB) exp_ferr++;
    else if (exp_q.size() >= CAP && !pop_same) exp_ovf++;
    else exp_q.push_back(word);
  endtask

  // mode: 0 plain, 1 last SCLK fall with CS_N rise, 2 raise rx_ready on the
  // push cycle, 3 measure CS_N-rise to rx_valid latency
  task automatic frame(input logic [63:0] bits, input int nbits, input int mode);
    int lat;
    CS_N = 1'b0;
    tick(4);
    for (int k = 0; k < nbits; k++) begin
      SCLK = 1'b1;
      SDI  = bits[k];
      tick(4);
      SCLK = 1'b0;
      if (mode == 1 && k == nbits - 1) CS_N = 1'b1;
      tick(4);
    end
    CS_N = 1'b1;
    model_close(bits[FB-1:0], nbits, mode == 2);
    if (mode == 2) begin
      lat = 0;
      while (busy && lat < 20) begin
        tick(1);
        lat++;
      end
      check("busy_drop_timeout", int'(busy), 0);
      rx_ready = 1'b1;
    end
    if (mode == 3) begin
      for (lat = 1; lat <= 20; lat++) begin
        tick(1);
        if (rx_valid) break;
      end
      check("latency_within_bound", int'(lat <= SYNC + 3), 1);
    end
    tick(8);
  endtask

  task automatic end_test(input string name, input int xfers);
    tick(12);
    check({name, "_frame_err_count"}, got_ferr, exp_ferr);
    check({name, "_overflow_count"}, got_ovf, exp_ovf);
    check({name, "_transfers"}, n_xfer - xfer_base, xfers);
    check({name, "_pending_words"}, exp_q.size(), 0);
    xfer_base = n_xfer;
  endtask

  // Monitor: counts pulses, pops the scoreboard on every transfer and checks
  // that a stalled word stays put.
  initial begin
    logic          stall_prev = 1'b0;
    logic [FB-1:0] data_prev = '0;
    logic [FB-1:0] exp_word;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        stall_prev = 1'b0;
      end else begin
        if (frame_err === 1'b1) got_ferr++;
        if (overflow === 1'b1) got_ovf++;
        if (stall_prev) begin
          check("stall_valid_held", int'(rx_valid), 1);
          check("stall_data_held", int'(rx_data), int'(data_prev));
        end
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
          n_xfer++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_word: got %h, required no word", rx_data);
          end else begin
            exp_word = exp_q.pop_front();
            $display("transfer: rx_data=%h expected=%h", rx_data, exp_word);
            check("rx_data", int'(rx_data), int'(exp_word));
          end
        end
        stall_prev = rx_valid && !rx_ready;
        data_prev  = rx_data;
      end
    end
  end

  initial begin
    logic [63:0] bits;
    int nb;

    tick(3);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_busy", int'(busy), 0);
    RST_N = 1'b1;
    tick(8);

    // good word, immediate consumer
    rx_ready = 1'b1;
    frame(64'hE000, FB, 3);
    end_test("e000", 1);

    // short and long frames
    frame({$urandom, $urandom}, 12, 0);
    frame({$urandom, $urandom}, 17, 0);
    end_test("bad_len", 0);

    // empty frame and a long saturating frame
    frame(64'h0, 0, 0);
    frame({$urandom, $urandom}, 40, 0);
    end_test("zero_and_40", 0);

    // last bit coincident with close
    frame(64'hFFFF, FB, 1);
    end_test("coincident", 1);

    // reset mid-frame, frame continues under reset release
    CS_N = 1'b0;
    tick(4);
    for (int k = 0; k < 8; k++) begin
      SCLK = 1'b1; SDI = k[0]; tick(4);
      SCLK = 1'b0; tick(4);
    end
    check("busy_before_reset", int'(busy), 1);
    RST_N = 1'b0;
    #1;
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_valid", int'(rx_valid), 0);
    tick(2);
    RST_N = 1'b1;
    for (int k = 0; k < 8; k++) begin
      SCLK = 1'b1; SDI = k[1]; tick(4);
      SCLK = 1'b0; tick(4);
    end
    CS_N = 1'b1;
    tick(10);
    check("midreset_busy", int'(busy), 0);
    frame(64'h3B90, FB, 0);
    end_test("midreset", 1);

    // overflow with a stalled consumer
    rx_ready = 1'b0;
    for (int i = 1; i <= CAP + 1; i++) frame(64'(i), FB, 0);
    tick(4);
    check("ovf_head_valid", int'(rx_valid), 1);
    check("ovf_head_data", int'(rx_data), 1);
    check("ovf_pulses", got_ovf, exp_ovf);
    rx_ready = 1'b1;
    end_test("overflow", CAP);

    // push and pop in the same cycle
    rx_ready = 1'b0;
    frame(64'hA5C3, FB, 0);
    frame(64'h5A3C, FB, 2);
    end_test("push_pop", 2);

    // randomized frames
    rx_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bits = {$urandom, $urandom};
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : FB;
      frame(bits, nb, 0);
    end
    end_test("random", n_xfer - xfer_base + exp_q.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmod_receiver.md
PMOD_RECEIVER -- requirements
Module: pmod_receiver

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 16: bits per chip-select frame.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per serial input, minimum 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output buffer entries, power of two; used only with PMOD_RX_FIFO_EN.
REQ-004 SHALL have port CLK  input  1  system clock; the only clock; all logic on its rising edge.
REQ-005 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port CS_N  input  1  chip select from the serial link, active low, asynchronous to CLK.
REQ-007 SHALL have port SDI  input  1  serial data from the link, asynchronous to CLK.
REQ-008 SHALL have port SCLK  input  1  serial clock from the link, asynchronous to CLK, at most CLK/8.
REQ-009 SHALL have port rx_data  output  FRAME_BITS  received word; valid only while rx_valid=1.
REQ-010 SHALL have port rx_valid  output  1  rx_data holds an unconsumed word.
REQ-011 SHALL have port rx_ready  input  1  consumer accepts the word; transfer occurs when rx_valid and rx_ready are both 1.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse when a frame closes with a bit count other than FRAME_BITS.
REQ-013 SHALL have port overflow  output  1  one-cycle pulse when a good word is dropped because the buffer is full.
REQ-014 SHALL have port busy  output  1  high while state is SHIFT.

Function
REQ-015 SHALL pass CS_N, SDI and SCLK through SYNC_STAGES flops, then one further register for edge detection.
REQ-016 SHALL sample synchronized SDI on each detected SCLK falling edge.
REQ-017 SHALL treat the first sampled bit as bit 0 (LSB first) and shift each new bit in at the MSB end, so that bit k lands at rx_data[k].
REQ-018 SHALL implement the FSM states WAIT_IDLE, IDLE, SHIFT and CLOSE.
REQ-019 WAIT_IDLE SHALL go to IDLE when synchronized CS_N=1.
REQ-020 IDLE SHALL go to SHIFT on a CS_N falling edge and clear the shift register and bit counter.
REQ-021 SHIFT SHALL go to CLOSE on a CS_N rising edge.
REQ-022 CLOSE SHALL go to IDLE after exactly one cycle.
REQ-023 In CLOSE, a bit count equal to FRAME_BITS SHALL push the word to the buffer; any other count SHALL pulse frame_err and discard the word.
REQ-024 A frame with zero bits SHALL pulse frame_err.
REQ-025 A frame with more than FRAME_BITS bits SHALL pulse frame_err; the bit counter SHALL saturate at FRAME_BITS+1 and never wrap.
REQ-026 When an SCLK falling edge and a CS_N rising edge are detected in the same cycle, the bit SHALL be sampled before the frame closes.
REQ-027 SCLK edges outside SHIFT SHALL be ignored.
REQ-028 Latency SHALL be at most SYNC_STAGES+3 CLK cycles from the CS_N rising edge at the pin to rx_valid=1.
REQ-029 On a push while the buffer is full, the new word SHALL be dropped, overflow SHALL pulse, and the stored contents SHALL be unchanged.
REQ-030 A pop and a push in the same cycle SHALL both succeed, including when the buffer is full.
REQ-031 rx_data and rx_valid SHALL remain stable while rx_valid=1 and rx_ready=0.

Reset
REQ-032 Asserting RST_N=0 SHALL immediately force rx_valid=0, frame_err=0, overflow=0, busy=0 and rx_data=0, empty the buffer, and clear all synchronizers to 1.
REQ-033 After reset, the FSM SHALL start in WAIT_IDLE, so that a frame already in progress is ignored rather than reported as an error.
REQ-034 Reset asserted mid-frame SHALL discard the partial word without pulsing frame_err.

Configuration
REQ-035 With PMOD_RX_FIFO_EN defined, the buffer SHALL be a FIFO_DEPTH-entry FIFO with first-word-fall-through output.
REQ-036 Without PMOD_RX_FIFO_EN, the buffer SHALL be a single holding register; full means rx_valid=1, and a push in the same cycle as a pop SHALL be accepted.

Structure
REQ-037 The FSM state typedef and the default FRAME_BITS constant SHALL reside in shared package pmod_pkg.
REQ-038 The FIFO SHALL be sub-module pmod_rx_fifo, instantiated only when PMOD_RX_FIFO_EN is defined.

Verification
REQ-039 The bench SHALL cover: 16'hE000 sent LSB first, rx_ready=1 -> rx_valid one pulse, rx_data=16'hE000, no error pulses.
REQ-040 The bench SHALL cover: frame of 12 bits, then frame of 17 bits -> two frame_err pulses, rx_valid stays 0.
REQ-041 The bench SHALL cover: rx_ready=0, five good frames 16'h0001..16'h0005 with FIFO enabled -> one overflow pulse on the 5th frame; pops then return 1,2,3,4.
REQ-042 The bench SHALL cover: RST_N pulsed low after 8 bits, CS_N held low, then 8 more bits and CS_N high -> no rx_valid, no frame_err; the next 16'h3B90 frame is received correctly.
REQ-043 The bench SHALL cover: last SCLK falling edge coincident with the CS_N rising edge on 16'hFFFF -> rx_data=16'hFFFF, no frame_err.
REQ-044 The bench SHALL cover: without the FIFO, rx_valid=1 held and a new frame arriving with rx_ready=1 on the push cycle -> old word popped, new word held, no overflow.
